// File: rtl/ahb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahb_pkg: shared AHB transfer/burst encodings and address helpers  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package ahb_pkg;

    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011,
        BURST_WRAP8  = 3'b100,
        BURST_INCR8  = 3'b101,
        BURST_WRAP16 = 3'b110,
        BURST_INCR16 = 3'b111
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } resp_state_e;

    // 0 means an unbounded burst (SINGLE/INCR).
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst_e'(hburst))
            BURST_WRAP4, BURST_INCR4:   return 5'd4;
            BURST_WRAP8, BURST_INCR8:   return 5'd8;
            BURST_WRAP16, BURST_INCR16: return 5'd16;
            default:                    return 5'd0;
        endcase
    endfunction

    // WRAP bursts keep the bits above the burst size; INCR uses a full mask.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0]        hburst);
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] incr;
        incr = addr + ADDR_W'(1);
        case (hburst_e'(hburst))
            BURST_WRAP4:  mask = ADDR_W'(3);
            BURST_WRAP8:  mask = ADDR_W'(7);
            BURST_WRAP16: mask = ADDR_W'(15);
            default:      mask = '1;
        endcase
        return (addr & ~mask) | (incr & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_burst_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahb_burst_tracker: beat counting, expected address, proto_err     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module ahb_burst_tracker
    import ahb_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          bus_cycle,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hburst,
    input  logic          hwrite,
    input  logic [AW-1:0] haddr,
    input  logic          addr_err,
    output logic          proto_err
);

    logic          r_active;
    logic [4:0]    r_beat_cnt;
    logic [AW-1:0] r_exp_addr;
    logic [2:0]    r_burst;
    logic          r_write;
    logic          r_err;

    logic          w_is_seq;
    logic          w_is_busy;
    logic          w_is_nonseq;
    logic          w_is_idle;
    logic          w_fixed;
    logic          w_violation;
    logic [4:0]    w_beats;

    always_comb begin
        w_is_seq    = bus_cycle && (htrans == TRANS_SEQ);
        w_is_busy   = bus_cycle && (htrans == TRANS_BUSY);
        w_is_nonseq = bus_cycle && (htrans == TRANS_NONSEQ);
        w_is_idle   = bus_cycle && (htrans == TRANS_IDLE);
        w_beats     = burst_beats(hburst);
        w_fixed     = (burst_beats(r_burst) != 5'd0);

        w_violation = 1'b0;
        if (w_is_busy && !r_active)
            w_violation = 1'b1;
        if (w_is_seq && (!r_active || (haddr != r_exp_addr) ||
                         (w_fixed && (r_beat_cnt == 5'd0)) ||
                         (hburst != r_burst) || (hwrite != r_write)))
            w_violation = 1'b1;
    end

    // r_beat_cnt counts SEQ beats still owed: the NONSEQ beat is deducted at load.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_active   <= 1'b0;
            r_beat_cnt <= 5'd0;
            r_exp_addr <= '0;
            r_burst    <= 3'd0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_violation)
                r_err <= 1'b1;
            if (addr_err) begin
                r_active   <= 1'b0;
                r_beat_cnt <= 5'd0;
            end else if (w_is_nonseq) begin
                r_active   <= (hburst != BURST_SINGLE);
                r_burst    <= hburst;
                r_write    <= hwrite;
                r_beat_cnt <= (w_beats == 5'd0) ? 5'd0 : (w_beats - 5'd1);
                r_exp_addr <= AW'(next_addr(ADDR_W'(haddr), hburst));
            end else if (w_is_seq) begin
                if (r_beat_cnt != 5'd0)
                    r_beat_cnt <= r_beat_cnt - 5'd1;
                r_exp_addr <= AW'(next_addr(ADDR_W'(haddr), r_burst));
            end else if (w_is_idle) begin
                r_active   <= 1'b0;
                r_beat_cnt <= 5'd0;
            end
        end
    end

    assign proto_err = r_err;

endmodule
`default_nettype wire

// File: rtl/ahb_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahb_mem_responder: byte-memory AHB responder with wait states     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module ahb_mem_responder
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 1,
    parameter int AW          = 8
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hburst,
    input  logic          hwrite,
    input  logic [7:0]    hwdata,
    input  logic          hready,
    output logic          hreadyout,
    output logic          hresp,
    output logic [7:0]    hrdata,
    output logic          proto_err
);

    localparam int         MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    resp_state_e       r_state;
    resp_state_e       w_next;
    logic [MEM_AW-1:0] r_addr;
    logic              r_write;
    logic [2:0]        r_wait_cnt;
    logic [7:0]        r_mem [DEPTH];

    logic              w_can_accept;
    logic              w_accept;
    logic              w_in_range;

    always_comb begin
        w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
        w_accept     = w_can_accept && hsel && hready && htrans[1];
        w_in_range   = (32'(haddr) < 32'(DEPTH));

        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (w_accept && w_in_range)
                    w_next = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
                else if (w_accept)
                    w_next = ST_ERR1;
                else
                    w_next = ST_IDLE;
            end
            ST_WAIT: begin
                if (r_wait_cnt == 3'd0)
                    w_next = ST_DATA;
            end
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase

        hreadyout = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
        hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        hrdata    = ((r_state == ST_DATA) && !r_write) ? r_mem[r_addr] : 8'h00;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= haddr[MEM_AW-1:0];
                r_write <= hwrite;
            end
            if ((w_next == ST_WAIT) && (r_state != ST_WAIT))
                r_wait_cnt <= WAIT_LOAD;
            else if ((r_state == ST_WAIT) && (r_wait_cnt != 3'd0))
                r_wait_cnt <= r_wait_cnt - 3'd1;
        end
    end

    // Reset forces ST_IDLE asynchronously, so an interrupted write never reaches this edge.
    always_ff @(posedge hclk) begin
        if ((r_state == ST_DATA) && r_write)
            r_mem[r_addr] <= hwdata;
    end

    ahb_burst_tracker #(
        .AW (AW)
    ) u_burst_tracker (
        .hclk      (hclk),
        .hreset    (hreset),
        .bus_cycle (hsel && hready && w_can_accept),
        .htrans    (htrans),
        .hburst    (hburst),
        .hwrite    (hwrite),
        .haddr     (haddr),
        .addr_err  (w_accept && !w_in_range),
        .proto_err (proto_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ahb_mem_responder: scoreboard bench, WAIT_STATES=1 and =0 DUTs |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_ahb_mem_responder;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000, B_WRAP4 = 3'b010, B_INCR4 = 3'b011, B_INCR8 = 3'b101;

    logic       hclk   = 1'b0;
    logic       hreset = 1'b1;
    logic       sel    = 1'b0;
    logic       cur    = 1'b0;
    logic [7:0] haddr  = 8'h00;
    logic [7:0] hwdata = 8'h00;
    logic [1:0] htrans = 2'b00;
    logic [2:0] hburst = 3'b000;
    logic       hwrite = 1'b0;

    logic       ro_a, resp_a, perr_a, ro_b, resp_b, perr_b;
    logic [7:0] rd_a, rd_b;
    logic       hready, hsel_a, hsel_b;
    logic       m_ro, m_resp;
    logic [7:0] m_rd;

    assign hready = cur ? ro_b : ro_a;
    assign hsel_a = sel && !cur;
    assign hsel_b = sel && cur;
    assign m_ro   = cur ? ro_b : ro_a;
    assign m_resp = cur ? resp_b : resp_a;
    assign m_rd   = cur ? rd_b : rd_a;

    always #5 hclk = ~hclk;

    ahb_mem_responder #(.DEPTH(128), .WAIT_STATES(1), .AW(8)) dut_a (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
        .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
        .hreadyout(ro_a), .hresp(resp_a), .hrdata(rd_a), .proto_err(perr_a)
    );

    ahb_mem_responder #(.DEPTH(128), .WAIT_STATES(0), .AW(8)) dut_b (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
        .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
        .hreadyout(ro_b), .hresp(resp_b), .hrdata(rd_b), .proto_err(perr_b)
    );

    typedef struct {
        string      name;
        int         waits;
        logic       resp;
        logic       chk_data;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_xfer(input string name, input int waits, input logic resp,
                               input logic chk, input logic [7:0] d);
        exp_t e;
        e.name = name; e.waits = waits; e.resp = resp; e.chk_data = chk; e.data = d;
        q.push_back(e);
    endtask

    // One address phase; wd is the write data for the data phase running alongside it.
    task automatic beat(input logic s, input logic [1:0] tr, input logic [2:0] bu,
                        input logic wr, input logic [7:0] a, input logic [7:0] wd);
        int n = 0;
        sel = s; htrans = tr; hburst = bu; hwrite = wr; haddr = a; hwdata = wd;
        @(negedge hclk);
        while (!hready && n < 16) begin
            @(negedge hclk);
            n++;
        end
        if (!hready) begin
            n_chk++;
            $display("FAIL beat_timeout: hready stuck 0 for addr 0x%0h", a);
        end
        @(posedge hclk);
        #1;
    endtask

    // Monitor: follows the bus pipeline and scores each completed data phase.
    bit   dp   = 1'b0;
    bit   wbad = 1'b0;
    int   wcnt = 0;
    exp_t m_e;
    initial begin
        forever begin
            @(negedge hclk);
            if (hreset) begin
                dp = 1'b0; wcnt = 0; wbad = 1'b0;
            end else begin
                if (dp) begin
                    if (!m_ro) begin
                        wcnt++;
                        if (q.size() > 0 && m_resp !== q[0].resp) wbad = 1'b1;
                    end else begin
                        n_chk++;
                        if (q.size() == 0) begin
                            $display("FAIL unexpected_xfer: completion with empty queue, resp %0b", m_resp);
                        end else begin
                            m_e = q.pop_front();
                            if (wcnt == m_e.waits && !wbad && m_resp === m_e.resp &&
                                (!m_e.chk_data || m_rd === m_e.data))
                                n_pass++;
                            else
                                $display("FAIL %s: waits %0d resp %0b rdata 0x%0h wait_resp_bad %0b, expected waits %0d resp %0b rdata 0x%0h",
                                         m_e.name, wcnt, m_resp, m_rd, wbad, m_e.waits, m_e.resp, m_e.data);
                        end
                        wcnt = 0; wbad = 1'b0;
                    end
                end
                if (!dp || m_ro) dp = sel && hready && htrans[1];
            end
        end
    end

    logic [7:0] wrap_a [4] = '{8'h0E, 8'h0F, 8'h0C, 8'h0D};
    logic [7:0] rb_d   [4] = '{8'h03, 8'h04, 8'h01, 8'h02};
    time        t0;

    initial begin
        repeat (2) @(posedge hclk);
        #1;
        check("rst_hreadyout_a", 32'(ro_a), 32'd1);
        check("rst_hresp_a", 32'(resp_a), 32'd0);
        check("rst_hrdata_a", 32'(rd_a), 32'd0);
        check("rst_proto_err_a", 32'(perr_a), 32'd0);
        check("rst_hreadyout_b", 32'(ro_b), 32'd1);
        check("rst_proto_err_b", 32'(perr_b), 32'd0);
        hreset = 1'b0;
        @(posedge hclk);
        #1;

        // write 0x5A to 0x10, read it back
        expect_xfer("wr_0x10", 1, 1'b0, 1'b0, 8'h00);
        beat(1'b1, T_NSEQ, B_SINGLE, 1'b1, 8'h10, 8'h00);
        expect_xfer("rd_0x10", 1, 1'b0, 1'b1, 8'h5A);
        beat(1'b1, T_NSEQ, B_SINGLE, 1'b0, 8'h10, 8'h5A);
        beat(1'b0, T_IDLE, B_SINGLE, 1'b0, 8'h00, 8'h00);

        // out-of-range accesses; the write must not alias onto 0x10
        expect_xfer("err_wr_0x90", 1, 1'b1, 1'b0, 8'h00);
        beat(1'b1, T_NSEQ, B_SINGLE, 1'b1, 8'h90, 8'h00);
        expect_xfer("err_rd_0x91", 1, 1'b1, 1'b1, 8'h00);
        beat(1'b1, T_NSEQ, B_SINGLE, 1'b0, 8'h91, 8'hEE);
        expect_xfer("rd_0x10_after_err", 1, 1'b0, 1'b1, 8'h5A);
        beat(1'b1, T_NSEQ, B_SINGLE, 1'b0, 8'h10, 8'h00);
        beat(1'b0, T_IDLE, B_SINGLE, 1'b0, 8'h00, 8'h00);
        check("err_proto_err", 32'(perr_a), 32'd0);

        // WRAP4 write burst at 0x0E, then read 0x0C..0x0F
        for (int i = 0; i < 4; i++) begin
            expect_xfer($sformatf("wrap4_wr_%0d", i), 1, 1'b0, 1'b0, 8'h00);
            beat(1'b1, (i == 0) ? T_NSEQ : T_SEQ, B_WRAP4, 1'b1, wrap_a[i], 8'(i));
        end
        for (int i = 0; i < 4; i++) begin
            expect_xfer($sformatf("wrap4_rd_0x%0h", 8'h0C + 8'(i)), 1, 1'b0, 1'b1, rb_d[i]);
            beat(1'b1, T_NSEQ, B_SINGLE, 1'b0, 8'h0C + 8'(i), (i == 0) ? 8'h04 : 8'h00);
        end
        beat(1'b0, T_IDLE, B_SINGLE, 1'b0, 8'h00, 8'h00);
        check("wrap4_proto_err", 32'(perr_a), 32'd0);

        // INCR4 with a wrong third-beat address
        for (int i = 0; i < 4; i++)
            expect_xfer($sformatf("incr4_wr_%0d", i), 1, 1'b0, 1'b0, 8'h00);
        beat(1'b1, T_NSEQ, B_INCR4, 1'b1, 8'h10, 8'h00);
        beat(1'b1, T_SEQ, B_INCR4, 1'b1, 8'h11, 8'h21);
        check("incr4_perr_before_bad", 32'(perr_a), 32'd0);
        beat(1'b1, T_SEQ, B_INCR4, 1'b1, 8'h22, 8'h22);
        check("incr4_perr_after_bad", 32'(perr_a), 32'd1);
        beat(1'b1, T_SEQ, B_INCR4, 1'b1, 8'h23, 8'h23);
        expect_xfer("incr4_rd_0x22", 1, 1'b0, 1'b1, 8'h23);
        beat(1'b1, T_NSEQ, B_SINGLE, 1'b0, 8'h22, 8'h24);
        beat(1'b0, T_IDLE, B_SINGLE, 1'b0, 8'h00, 8'h00);
        check("incr4_perr_sticky", 32'(perr_a), 32'd1);

        // reset during the WAIT cycle of a write
        expect_xfer("wr_0x20_pre", 1, 1'b0, 1'b0, 8'h00);
        beat(1'b1, T_NSEQ, B_SINGLE, 1'b1, 8'h20, 8'h00);
        beat(1'b1, T_NSEQ, B_SINGLE, 1'b1, 8'h20, 8'h77);
        sel = 1'b0; htrans = T_IDLE; hwdata = 8'h99;
        check("wait_state_hreadyout", 32'(ro_a), 32'd0);
        #1 hreset = 1'b1;
        #1;
        check("async_rst_hreadyout", 32'(ro_a), 32'd1);
        check("async_rst_hresp", 32'(resp_a), 32'd0);
        check("async_rst_proto_err", 32'(perr_a), 32'd0);
        @(posedge hclk);
        #1 hreset = 1'b0;
        expect_xfer("rd_0x20_after_rst", 1, 1'b0, 1'b1, 8'h77);
        beat(1'b1, T_NSEQ, B_SINGLE, 1'b0, 8'h20, 8'h00);
        beat(1'b0, T_IDLE, B_SINGLE, 1'b0, 8'h00, 8'h00);

        // zero-wait DUT: INCR8 write, then INCR8 read with BUSY after beat 2
        cur = 1'b1;
        @(posedge hclk);
        #1;
        for (int i = 0; i < 8; i++) begin
            expect_xfer($sformatf("b_wr_%0d", i), 0, 1'b0, 1'b0, 8'h00);
            beat(1'b1, (i == 0) ? T_NSEQ : T_SEQ, B_INCR8, 1'b1, 8'(i),
                 (i == 0) ? 8'h00 : 8'hA0 + 8'(i - 1));
        end
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                beat(1'b1, T_BUSY, B_INCR8, 1'b0, 8'h03, 8'h00);
                check("busy_hreadyout", 32'(ro_b), 32'd1);
                check("busy_hresp", 32'(resp_b), 32'd0);
            end
            expect_xfer($sformatf("b_rd_%0d", i), 0, 1'b0, 1'b1, 8'hA0 + 8'(i));
            beat(1'b1, (i == 0) ? T_NSEQ : T_SEQ, B_INCR8, 1'b0, 8'(i), (i == 0) ? 8'hA7 : 8'h00);
        end
        check("b_rd_cycles", 32'(($time - t0) / 10), 32'd9);
        beat(1'b0, T_IDLE, B_SINGLE, 1'b0, 8'h00, 8'h00);
        check("b_proto_err", 32'(perr_b), 32'd0);

        repeat (3) @(posedge hclk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
